// File: rtl/i2c_seq_matcher.sv
// I2C bus monitor: synchronises scl/sda, deserialises bytes after START and
// checks the frame against a programmable byte pattern that must end in STOP.
module i2c_seq_matcher #(
  parameter int unsigned NBYTES      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LW          = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scl,
  input  logic                sda,
  input  logic                en,
  input  logic [LW-1:0]       pat_len,
  input  logic [8*NBYTES-1:0] pattern,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                ack_bit,
  output logic                match,
  output logic                mismatch,
  output logic                busy,
  output logic [2:0]          state_o
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_ACK     = 3'd2,
    S_MATCHED = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;

  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [IW-1:0]          r_idx;
  logic [7:0]             r_shift;
  logic [8*NBYTES-1:0]    r_pat;
  logic [LW-1:0]          r_len;

  state_t                 w_state_nxt;
  logic [2:0]             w_bit_cnt_nxt;
  logic [IW-1:0]          w_idx_nxt;
  logic [7:0]             w_shift_nxt;
  logic [8*NBYTES-1:0]    w_pat_nxt;
  logic [LW-1:0]          w_len_nxt;
  logic [7:0]             w_bd_nxt;
  logic                   w_ack_nxt;
  logic                   w_bv_nxt;
  logic                   w_match_nxt;
  logic                   w_mm_nxt;

  logic                   w_scl;
  logic                   w_sda;
  logic                   w_start;
  logic                   w_stop;
  logic                   w_rise;
  logic [LW-1:0]          w_len_clamped;
  logic [7:0]             w_pat_byte;
  logic                   w_last;

  // Pin synchronisers plus one history flop; reset to the idle-bus level so no event fires on release
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
      r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  // Bus event decode; START/STOP mask a coincident RISE
  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_start = w_scl & r_sda_hist & ~w_sda;
  assign w_stop  = w_scl & ~r_sda_hist & w_sda;
  assign w_rise  = ~r_scl_hist & w_scl & ~w_start & ~w_stop;

  assign w_len_clamped = (pat_len > LW'(NBYTES)) ? LW'(NBYTES) : pat_len;
  assign w_pat_byte    = r_pat[{r_idx, 3'b000} +: 8];
  assign w_last        = ((32'(r_idx) + 32'd1) == 32'(r_len));

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_bd_nxt      = byte_data;
    w_ack_nxt     = ack_bit;
    w_bv_nxt      = 1'b0;
    w_match_nxt   = 1'b0;
    w_mm_nxt      = 1'b0;

    if (!en) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      // Any START (first or repeated) restarts the frame silently
      w_pat_nxt     = pattern;
      w_len_nxt     = w_len_clamped;
      w_bit_cnt_nxt = 3'd0;
      w_idx_nxt     = '0;
      w_state_nxt   = (w_len_clamped == '0) ? S_SKIP : S_SHIFT;
    end else if (w_stop) begin
      case (r_state)
        S_SHIFT, S_ACK: w_mm_nxt    = 1'b1;
        S_MATCHED:      w_match_nxt = 1'b1;
        default:        ;
      endcase
      w_state_nxt = S_IDLE;
    end else if (w_rise) begin
      case (r_state)
        S_SHIFT: begin
          w_shift_nxt   = {r_shift[6:0], w_sda};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_ACK;
          end
        end
        S_ACK: begin
          w_bd_nxt  = r_shift;
          w_ack_nxt = w_sda;
          w_bv_nxt  = 1'b1;
          if ((r_shift != w_pat_byte) || w_sda) begin
            w_state_nxt = S_SKIP;
            w_mm_nxt    = 1'b1;
          end else if (w_last) begin
            w_state_nxt = S_MATCHED;
          end else begin
            w_idx_nxt     = r_idx + IW'(1);
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = S_SHIFT;
          end
        end
        S_MATCHED: begin
          w_state_nxt = S_SKIP;
          w_mm_nxt    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_idx      <= '0;
      r_shift    <= 8'd0;
      r_pat      <= '0;
      r_len      <= '0;
      byte_data  <= 8'd0;
      ack_bit    <= 1'b0;
      byte_valid <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_pat      <= w_pat_nxt;
      r_len      <= w_len_nxt;
      byte_data  <= w_bd_nxt;
      ack_bit    <= w_ack_nxt;
      byte_valid <= w_bv_nxt;
      match      <= w_match_nxt;
      mismatch   <= w_mm_nxt;
      busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_i2c_seq_matcher.sv
// Directed bench for i2c_seq_matcher: bit-banged I2C frames, pulse counters
// sampled on the falling clock edge, hand-computed expectations.
module tb_i2c_seq_matcher;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned LW     = $clog2(NBYTES + 1);
  localparam int unsigned H      = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                scl;
  logic                sda;
  logic                en;
  logic [LW-1:0]       pat_len;
  logic [8*NBYTES-1:0] pattern;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                ack_bit;
  logic                match;
  logic                mismatch;
  logic                busy;
  logic [2:0]          state_o;

  int n_checks = 0;
  int n_errors = 0;

  int bv_cnt = 0, match_cnt = 0, mm_cnt = 0, bvmm_cnt = 0, viol_cnt = 0;
  logic [7:0] bd_last = 8'h00, bd_prev = 8'h00;
  int b0, m0, x0, bm0;

  i2c_seq_matcher #(.NBYTES(NBYTES), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .en(en),
    .pat_len(pat_len), .pattern(pattern),
    .byte_valid(byte_valid), .byte_data(byte_data), .ack_bit(ack_bit),
    .match(match), .mismatch(mismatch), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping away from the active edge
  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      bd_prev = bd_last;
      bd_last = byte_data;
      if (mismatch) bvmm_cnt++;
    end
    if (match) match_cnt++;
    if (mismatch) mm_cnt++;
    if (match && (mismatch || byte_valid)) viol_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b0 = bv_cnt; m0 = match_cnt; x0 = mm_cnt; bm0 = bvmm_cnt;
  endtask

  task automatic i2c_start();
    if (!(scl && sda)) begin
      scl = 1'b0; wt(H);
      sda = 1'b1; wt(H);
      scl = 1'b1; wt(H);
    end
    sda = 1'b0; wt(H);
  endtask

  task automatic i2c_stop();
    if (!(scl && !sda)) begin
      scl = 1'b0; wt(H);
      sda = 1'b0; wt(H);
      scl = 1'b1; wt(H);
    end
    sda = 1'b1; wt(H);
  endtask

  // Bit leaves scl high so a following STOP/START needs no extra clock
  task automatic i2c_bit(input logic b);
    scl = 1'b0; wt(H);
    sda = b;    wt(H);
    scl = 1'b1; wt(H);
  endtask

  task automatic i2c_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_bit(ack);
  endtask

  initial begin
    reset = 1'b1; scl = 1'b1; sda = 1'b1; en = 1'b1;
    pat_len = LW'(2); pattern = 32'h0000_55A0;
    wt(4);
    reset = 1'b0;
    wt(6);

    // Reset state
    chk("rst state", 32'(state_o), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bv", 32'(byte_valid), 32'd0);
    chk("rst bdata", 32'(byte_data), 32'd0);
    chk("rst match", 32'(match), 32'd0);
    chk("rst mm", 32'(mismatch), 32'd0);

    // Valid two-byte frame
    snap();
    i2c_start();
    chk("ok start st", 32'(state_o), 32'd1);
    chk("ok start busy", 32'(busy), 32'd1);
    i2c_byte(8'hA0, 1'b0);
    chk("ok b0 st", 32'(state_o), 32'd1);
    i2c_byte(8'h55, 1'b0);
    chk("ok b1 st", 32'(state_o), 32'd3);
    i2c_stop();
    chk("ok match", 32'(match_cnt - m0), 32'd1);
    chk("ok mm", 32'(mm_cnt - x0), 32'd0);
    chk("ok bv", 32'(bv_cnt - b0), 32'd2);
    chk("ok byte0", 32'(bd_prev), 32'hA0);
    chk("ok byte1", 32'(bd_last), 32'h55);
    chk("ok ack", 32'(ack_bit), 32'd0);
    chk("ok end st", 32'(state_o), 32'd0);
    chk("ok end busy", 32'(busy), 32'd0);

    // Wrong second byte
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h54, 1'b0);
    chk("bad st", 32'(state_o), 32'd4);
    chk("bad bv+mm", 32'(bvmm_cnt - bm0), 32'd1);
    chk("bad bdata", 32'(byte_data), 32'h54);
    i2c_stop();
    chk("bad match", 32'(match_cnt - m0), 32'd0);
    chk("bad mm", 32'(mm_cnt - x0), 32'd1);
    chk("bad end st", 32'(state_o), 32'd0);

    // NACK on first byte, following byte ignored
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b1);
    chk("nack mm", 32'(mm_cnt - x0), 32'd1);
    chk("nack ack", 32'(ack_bit), 32'd1);
    chk("nack st", 32'(state_o), 32'd4);
    i2c_byte(8'h55, 1'b0);
    chk("nack bv", 32'(bv_cnt - b0), 32'd1);
    i2c_stop();
    chk("nack match", 32'(match_cnt - m0), 32'd0);
    chk("nack end st", 32'(state_o), 32'd0);

    // STOP after 5 data bits
    snap();
    i2c_start();
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b0);
    i2c_stop();
    chk("short mm", 32'(mm_cnt - x0), 32'd1);
    chk("short bv", 32'(bv_cnt - b0), 32'd0);
    chk("short st", 32'(state_o), 32'd0);

    // Repeated START restarts silently
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_start();
    chk("rs mm", 32'(mm_cnt - x0), 32'd0);
    chk("rs st", 32'(state_o), 32'd1);
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h55, 1'b0);
    i2c_stop();
    chk("rs match", 32'(match_cnt - m0), 32'd1);
    chk("rs mm end", 32'(mm_cnt - x0), 32'd0);
    chk("rs bv", 32'(bv_cnt - b0), 32'd3);

    // Reset mid-byte, then a normal frame
    snap();
    i2c_start();
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
    scl = 1'b0; wt(H);
    reset = 1'b1; wt(2);
    chk("mrst st", 32'(state_o), 32'd0);
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst bdata", 32'(byte_data), 32'd0);
    chk("mrst ack", 32'(ack_bit), 32'd0);
    reset = 1'b0; wt(H);
    chk("mrst st2", 32'(state_o), 32'd0);
    chk("mrst mm", 32'(mm_cnt - x0), 32'd0);
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h55, 1'b0);
    i2c_stop();
    chk("mrst match", 32'(match_cnt - m0), 32'd1);
    chk("mrst mm end", 32'(mm_cnt - x0), 32'd0);

    // Zero-length pattern goes straight to SKIP
    pat_len = LW'(0);
    snap();
    i2c_start();
    chk("zero st", 32'(state_o), 32'd4);
    chk("zero busy", 32'(busy), 32'd1);
    i2c_byte(8'hA0, 1'b0);
    i2c_stop();
    chk("zero st end", 32'(state_o), 32'd0);
    chk("zero pulses", 32'((match_cnt - m0) + (mm_cnt - x0) + (bv_cnt - b0)), 32'd0);
    pat_len = LW'(2);

    // Extra data after a full match
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h55, 1'b0);
    i2c_bit(1'b1);
    chk("extra mm", 32'(mm_cnt - x0), 32'd1);
    chk("extra st", 32'(state_o), 32'd4);
    i2c_stop();
    chk("extra match", 32'(match_cnt - m0), 32'd0);
    chk("extra end st", 32'(state_o), 32'd0);

    // en=0 mid-frame forces IDLE and ignores the bus
    snap();
    i2c_start();
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
    en = 1'b0; wt(2);
    chk("dis st", 32'(state_o), 32'd0);
    chk("dis busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) i2c_bit(1'b0);
    i2c_stop();
    chk("dis pulses", 32'((match_cnt - m0) + (mm_cnt - x0) + (bv_cnt - b0)), 32'd0);
    en = 1'b1; wt(H);

    // pat_len above NBYTES clamps to NBYTES (bytes 2,3 of the pattern are 00)
    pat_len = LW'(7);
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h55, 1'b0);
    i2c_byte(8'h00, 1'b0);
    chk("clamp st3", 32'(state_o), 32'd1);
    i2c_byte(8'h00, 1'b0);
    chk("clamp st4", 32'(state_o), 32'd3);
    i2c_stop();
    chk("clamp match", 32'(match_cnt - m0), 32'd1);
    chk("clamp mm", 32'(mm_cnt - x0), 32'd0);

    chk("pulse overlap", 32'(viol_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
